pipelined_long_multiplier_hs: RTL and testbench
===============================================

// Module: pipelined_long_multiplier_hs
// PURPOSE
//  Fully pipelined shift-add (long) multiplier; DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH product.
//  B processed PRODUCT_PER_STAGE bits per stage; register bank after every stage.
//  Adds valid/ready handshake with global stall and per-transaction signed/unsigned mode.
//  Sits in integer execution datapaths as a throughput-1 multiplier.
// PARAMETERS
//  DATA_WIDTH        8  operand width; power of 2, >= 4
//  PRODUCT_PER_STAGE 4  B bits consumed per stage; power of 2, divides DATA_WIDTH
//  (derived) NUM_STAGES = DATA_WIDTH / PRODUCT_PER_STAGE
// PORTS
//  clk_i        in   1             clock, rising edge
//  rst_i        in   1             asynchronous, active-high reset
//  operand_A_i  in   DATA_WIDTH    multiplicand
//  operand_B_i  in   DATA_WIDTH    multiplier
//  signed_i     in   1             1: two's-complement operands; 0: unsigned
//  valid_i      in   1             input transaction valid
//  ready_o      out  1             block accepts input this cycle
//  product_o    out  2*DATA_WIDTH  result
//  valid_o      out  1             product_o valid
//  ready_i      in   1             downstream accepts product_o
//  flush_i      in   1             only with LONG_MULT_FLUSH_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits, valid_o, product_o = 0; ready_o = 1.
//  - Accept when valid_i && ready_o. Stall = valid_o && !ready_i; ready_o = !stall.
//  - Stall freezes every stage register, bubbles included; no bubble collapsing.
//  - Latency NUM_STAGES cycles, accept edge to valid_o; throughput 1/cycle when unstalled.
//  - Stage 0 input: |A|, |B| (abs only if signed_i), neg = signed_i & (A[MSB] ^ B[MSB]).
//    Magnitudes are DATA_WIDTH-bit unsigned; |-2^(N-1)| = 2^(N-1) is exact.
//    Partial-product input = 0, carry input = 0.
//  - Stage k, rows i = 0..PRODUCT_PER_STAGE-1, uses B bit k*PRODUCT_PER_STAGE + i.
//    Per row: AND-row + previous partial product (DATA_WIDTH-1 b) + carry.
//    Row emits one final low bit, a new partial product and a carry.
//  - Per-stage register: |A|, unconsumed B bits, partial product, carry.
//    Also: low result bits collected so far, neg, valid.
//  - Magnitude = {carry, partial, low DATA_WIDTH bits}.
//  - product_o = neg ? -magnitude : magnitude; the 2*DATA_WIDTH two's complement negate is combinational from the last register.
//  - product_o holds stable while valid_o && !ready_i.
//  - Invalid slots still clock data; their contents are don't-care.
//  - Reset mid-operation: all in-flight results discarded; no valid_o until new accepts.
// CONFIGURATION
//  LONG_MULT_FLUSH_EN defined:
//    flush_i port exists. flush_i=1 clears all valid bits next edge, overriding stall.
//    ready_o = 1 that cycle, but an input presented with flush_i is dropped.
//  Undefined: no flush_i port; pipeline drains only by handshake.
// STRUCTURE
//  Package long_mult_pkg:
//    - NUM_STAGES function
//    - stage_reg_t packed struct (a_mag, b_rem, partial, carry, low_bits, neg, valid)
//  Sub-module long_multiplier_product_row: one add row.
//  Sub-module pipelined_long_multiplier_stage: combinational, PRODUCT_PER_STAGE rows.
//  Top: NUM_STAGES stage instances via generate, stage registers, abs/negate, handshake.
// TESTING (DATA_WIDTH=8, PRODUCT_PER_STAGE=4, latency 2)
//  - Unsigned 200*150, ready_i=1 -> 16'h7530 with valid_o 2 cycles after accept.
//  - Unsigned 255*255 -> 16'hFE01; signed 8'hFD*8'h05 (-3*5) -> 16'hFFF1.
//  - Signed 8'h80*8'h80 -> 16'h4000; signed 8'h80*8'h01 -> 16'hFF80.
//  - Back-to-back stream, 3 ops, ready_i=1 -> 3 consecutive valid_o cycles, in order.
//    Then ready_i=0 for 4 cycles -> ready_o=0, product_o held; release resumes with no loss/dup.
//  - Assert rst_i with 2 ops in flight -> valid_o=0 immediately, product_o=0.
//    After release, no valid_o until a new accept.
//  - With LONG_MULT_FLUSH_EN: flush_i with 2 in flight + stall -> valid_o=0 next cycle.
//    Next accepted op returns correctly.
//  - Random signed/unsigned mix, 10k ops, random ready_i -> matches reference model.

Source files
------------

// File: rtl/long_mult_pkg.sv
// Shared types and helpers for the pipelined long multiplier.
// stage_reg_t is sized from LM_DATA_WIDTH; the top checks that its
// DATA_WIDTH parameter agrees, so change both together.
package long_mult_pkg;

  localparam int LM_DATA_WIDTH        = 8;
  localparam int LM_PRODUCT_PER_STAGE = 4;

  // Number of pipeline stages for a given operand width and bits per stage.
  function automatic int num_stages(input int data_width, input int product_per_stage);
    return data_width / product_per_stage;
  endfunction

  // Contents of one pipeline register bank.
  //   a_mag    : |A|, carried unchanged through the pipe
  //   b_rem    : B magnitude bits not yet consumed, LSB = next bit to use
  //   partial  : running upper partial product below the carry
  //   carry    : top bit of the running upper partial product
  //   low_bits : final low result bits, shifted in from the MSB end
  //   neg      : result must be negated at the output
  //   valid    : slot holds a live transaction
  typedef struct packed {
    logic [LM_DATA_WIDTH-1:0] a_mag;
    logic [LM_DATA_WIDTH-1:0] b_rem;
    logic [LM_DATA_WIDTH-2:0] partial;
    logic                     carry;
    logic [LM_DATA_WIDTH-1:0] low_bits;
    logic                     neg;
    logic                     valid;
  } stage_reg_t;

endpackage

// File: rtl/long_multiplier_product_row.sv
// One shift-add row: adds (A AND b_bit) to the running upper partial
// product {carry_in, partial_in}. The sum's LSB is a finished result bit;
// the remaining bits become the next row's partial product and carry.
module long_multiplier_product_row #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic                  b_bit,
  input  logic [DATA_WIDTH-2:0] partial_in,
  input  logic                  carry_in,
  output logic                  low_bit,
  output logic [DATA_WIDTH-2:0] partial_out,
  output logic                  carry_out
);

  logic [DATA_WIDTH:0] sum;

  // Row sum: gated multiplicand plus the upper accumulator (carry is its MSB).
  always_comb begin
    sum = {1'b0, a_mag & {DATA_WIDTH{b_bit}}} + {1'b0, carry_in, partial_in};
  end

  assign low_bit     = sum[0];
  assign partial_out = sum[DATA_WIDTH-1:1];
  assign carry_out   = sum[DATA_WIDTH];

endmodule

// File: rtl/pipelined_long_multiplier_stage.sv
// Combinational body of one pipeline stage: PRODUCT_PER_STAGE chained
// add rows, each consuming the next unconsumed bit of |B|.
module pipelined_long_multiplier_stage #(
  parameter int DATA_WIDTH        = 8,
  parameter int PRODUCT_PER_STAGE = 4
) (
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic [DATA_WIDTH-1:0] b_rem_in,
  input  logic [DATA_WIDTH-2:0] partial_in,
  input  logic                  carry_in,
  input  logic [DATA_WIDTH-1:0] low_in,
  output logic [DATA_WIDTH-1:0] b_rem_out,
  output logic [DATA_WIDTH-2:0] partial_out,
  output logic                  carry_out,
  output logic [DATA_WIDTH-1:0] low_out
);

  // Chain nodes: index i is the input of row i, index PRODUCT_PER_STAGE is the stage output.
  logic [DATA_WIDTH-2:0]        partial_c [PRODUCT_PER_STAGE+1];
  logic                         carry_c   [PRODUCT_PER_STAGE+1];
  logic [DATA_WIDTH-1:0]        low_c     [PRODUCT_PER_STAGE+1];
  logic [PRODUCT_PER_STAGE-1:0] row_low;

  assign partial_c[0] = partial_in;
  assign carry_c[0]   = carry_in;
  assign low_c[0]     = low_in;

  for (genvar i = 0; i < PRODUCT_PER_STAGE; i++) begin : g_row
    long_multiplier_product_row #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_row (
      .a_mag      (a_mag),
      .b_bit      (b_rem_in[i]),
      .partial_in (partial_c[i]),
      .carry_in   (carry_c[i]),
      .low_bit    (row_low[i]),
      .partial_out(partial_c[i+1]),
      .carry_out  (carry_c[i+1])
    );

    // Each finished bit enters at the MSB so that after all DATA_WIDTH rows
    // the first finished bit has arrived at bit 0.
    assign low_c[i+1] = {row_low[i], low_c[i][DATA_WIDTH-1:1]};
  end

  assign partial_out = partial_c[PRODUCT_PER_STAGE];
  assign carry_out   = carry_c[PRODUCT_PER_STAGE];
  assign low_out     = low_c[PRODUCT_PER_STAGE];
  assign b_rem_out   = b_rem_in >> PRODUCT_PER_STAGE;

endmodule

// File: rtl/pipelined_long_multiplier_hs.sv
// Fully pipelined shift-add multiplier, DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH,
// with valid/ready handshake, global stall and per-transaction signed mode.
// Optional feature macro: LONG_MULT_FLUSH_EN (adds flush_i, clears the pipe).
//
// Handshake: an input transfers on a rising edge where valid_i && ready_o;
// an output transfers where valid_o && ready_i. When valid_o is high and
// ready_i low the whole pipe stalls (bubbles included), ready_o drops and
// product_o/valid_o hold. Flush, when built in, wins over stall and drops
// any input presented in the same cycle.
module pipelined_long_multiplier_hs
  import long_mult_pkg::*;
#(
  parameter int DATA_WIDTH        = LM_DATA_WIDTH,
  parameter int PRODUCT_PER_STAGE = LM_PRODUCT_PER_STAGE
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   operand_A_i,
  input  logic [DATA_WIDTH-1:0]   operand_B_i,
  input  logic                    signed_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic                    valid_o,
  input  logic                    ready_i
`ifdef LONG_MULT_FLUSH_EN
  ,
  input  logic                    flush_i
`endif
);

  localparam int NUM_STAGES = num_stages(DATA_WIDTH, PRODUCT_PER_STAGE);

  // The register struct is sized by the package; refuse mismatched builds.
  if (DATA_WIDTH != LM_DATA_WIDTH) begin : g_width_check
    $error("DATA_WIDTH must equal long_mult_pkg::LM_DATA_WIDTH");
  end

  logic                    flush;
  logic                    stall;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   a_abs;
  logic [DATA_WIDTH-1:0]   b_abs;
  logic [2*DATA_WIDTH-1:0] magnitude;
  stage_reg_t              head;
  stage_reg_t              stage_in [NUM_STAGES];
  stage_reg_t              stage_d  [NUM_STAGES];
  stage_reg_t              stage_q  [NUM_STAGES];

`ifdef LONG_MULT_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign stall   = stage_q[NUM_STAGES-1].valid && !ready_i;
  assign ready_o = flush || !stall;
  assign accept  = valid_i && ready_o && !flush;

  // Stage 0 input: operand magnitudes and result sign; accumulators start at zero.
  always_comb begin
    a_abs = (signed_i && operand_A_i[DATA_WIDTH-1]) ? -operand_A_i : operand_A_i;
    b_abs = (signed_i && operand_B_i[DATA_WIDTH-1]) ? -operand_B_i : operand_B_i;
    head          = '0;
    head.a_mag    = a_abs;
    head.b_rem    = b_abs;
    head.partial  = '0;
    head.carry    = 1'b0;
    head.low_bits = '0;
    head.neg      = signed_i & (operand_A_i[DATA_WIDTH-1] ^ operand_B_i[DATA_WIDTH-1]);
    head.valid    = accept;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [DATA_WIDTH-1:0] b_rem_nx;
    logic [DATA_WIDTH-2:0] partial_nx;
    logic                  carry_nx;
    logic [DATA_WIDTH-1:0] low_nx;

    if (k == 0) begin : g_first
      assign stage_in[k] = head;
    end else begin : g_next
      assign stage_in[k] = stage_q[k-1];
    end

    pipelined_long_multiplier_stage #(
      .DATA_WIDTH       (DATA_WIDTH),
      .PRODUCT_PER_STAGE(PRODUCT_PER_STAGE)
    ) u_stage (
      .a_mag      (stage_in[k].a_mag),
      .b_rem_in   (stage_in[k].b_rem),
      .partial_in (stage_in[k].partial),
      .carry_in   (stage_in[k].carry),
      .low_in     (stage_in[k].low_bits),
      .b_rem_out  (b_rem_nx),
      .partial_out(partial_nx),
      .carry_out  (carry_nx),
      .low_out    (low_nx)
    );

    // Next register contents: arithmetic fields from the rows, the rest passes through.
    always_comb begin
      stage_d[k]          = stage_in[k];
      stage_d[k].b_rem    = b_rem_nx;
      stage_d[k].partial  = partial_nx;
      stage_d[k].carry    = carry_nx;
      stage_d[k].low_bits = low_nx;
    end

    // Register bank: flush clears valid even under stall; stall freezes everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stage_q[k] <= '0;
      end else if (flush) begin
        stage_q[k].valid <= 1'b0;
      end else if (!stall) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Output: reassemble the magnitude and apply the sign from the last bank.
  always_comb begin
    magnitude = {stage_q[NUM_STAGES-1].carry,
                 stage_q[NUM_STAGES-1].partial,
                 stage_q[NUM_STAGES-1].low_bits};
    product_o = stage_q[NUM_STAGES-1].neg ? -magnitude : magnitude;
    valid_o   = stage_q[NUM_STAGES-1].valid;
  end

endmodule

// File: tb/tb_pipelined_long_multiplier_hs.sv
// Bench for pipelined_long_multiplier_hs (DATA_WIDTH=8, PRODUCT_PER_STAGE=4).
// Build with LONG_MULT_FLUSH_EN defined to exercise flush_i as well.
module tb_pipelined_long_multiplier_hs;

  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [W-1:0]   operand_A_i;
  logic [W-1:0]   operand_B_i;
  logic           signed_i;
  logic           valid_i;
  logic           ready_o;
  logic [2*W-1:0] product_o;
  logic           valid_o;
  logic           ready_i;
`ifdef LONG_MULT_FLUSH_EN
  logic           flush_i;
`endif

  logic [2*W-1:0] exp_q[$];
  int             checks = 0;
  int             errors = 0;
  bit             rand_on;
  bit             prev_stall;
  logic [2*W-1:0] prev_product;

  pipelined_long_multiplier_hs #(
    .DATA_WIDTH(W),
    .PRODUCT_PER_STAGE(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .operand_A_i(operand_A_i),
    .operand_B_i(operand_B_i),
    .signed_i   (signed_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .product_o  (product_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
`ifdef LONG_MULT_FLUSH_EN
    ,
    .flush_i    (flush_i)
`endif
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Reference: plain integer multiply of the operands as interpreted by signed_i.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint pa;
    longint pb;
    longint p;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Driver: present one operation and hold it until accepted; push its expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [2*W-1:0] exp);
    bit done;
    int waited;
    operand_A_i = a;
    operand_B_i = b;
    signed_i    = s;
    valid_i     = 1'b1;
    done        = 1'b0;
    waited      = 0;
    while (!done) begin
      @(negedge clk_i);
      done = ready_o;
      @(posedge clk_i);
      #1;
      if (done) begin
        exp_q.push_back(exp);
      end else begin
        waited++;
        if (waited > 1000) begin
          errors++;
          $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
          done = 1'b1;
        end
      end
    end
    valid_i = 1'b0;
  endtask

  // Wait (bounded) for every expected result to come out.
  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor / scoreboard: pop on every output transfer; check hold during stalls.
  task automatic monitor_loop;
    logic [2*W-1:0] exp;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", valid_o, 1);
          check("hold_product", product_o, prev_product);
        end
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none at %0t", product_o, $time);
          end else begin
            exp = exp_q.pop_front();
            check("product", product_o, exp);
          end
        end
`ifdef LONG_MULT_FLUSH_EN
        prev_stall = valid_o && !ready_i && !flush_i;
`else
        prev_stall = valid_o && !ready_i;
`endif
        prev_product = product_o;
      end
    end
  endtask

  function automatic logic [W-1:0] pick_operand;
    logic [W-1:0] corner [5];
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    logic [5:0]   vpat;
    bit           quiet;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;

    rst_i       = 1'b1;
    operand_A_i = '0;
    operand_B_i = '0;
    signed_i    = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b1;
    prev_stall  = 1'b0;
    prev_product = '0;
    rand_on     = 1'b0;
`ifdef LONG_MULT_FLUSH_EN
    flush_i     = 1'b0;
`endif
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (2) tick();
    check("reset_valid_o", valid_o, 0);
    check("reset_product_o", product_o, 0);
    check("reset_ready_o", ready_o, 1);
    rst_i = 1'b0;
    tick();

    // Latency: valid_o rises on the second edge counting the accept edge
    send(8'd200, 8'd150, 1'b0, 16'h7530);
    check("latency_early", valid_o, 0);
    tick();
    check("latency_valid", valid_o, 1);
    drain();

    // Directed corner products
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    send(8'hFD, 8'h05, 1'b1, 16'hFFF1);
    send(8'h80, 8'h80, 1'b1, 16'h4000);
    send(8'h80, 8'h01, 1'b1, 16'hFF80);
    send(8'h80, 8'h80, 1'b0, 16'h4000);
    send(8'hFF, 8'hFF, 1'b1, 16'h0001);
    drain();

    // Back-to-back stream of three: three consecutive valid_o cycles
    for (int c = 0; c < 6; c++) begin
      valid_i = 1'b0;
      if (c == 0) begin
        operand_A_i = 8'd3;   operand_B_i = 8'd7;   signed_i = 1'b0; valid_i = 1'b1;
        exp_q.push_back(16'h0015);
      end else if (c == 1) begin
        operand_A_i = 8'hFF;  operand_B_i = 8'h02;  signed_i = 1'b1; valid_i = 1'b1;
        exp_q.push_back(16'hFFFE);
      end else if (c == 2) begin
        operand_A_i = 8'd100; operand_B_i = 8'd100; signed_i = 1'b0; valid_i = 1'b1;
        exp_q.push_back(16'h2710);
      end
      @(negedge clk_i);
      vpat[c] = valid_o;
      if (c < 3) check("stream_ready", ready_o, 1);
      tick();
    end
    check("stream_pattern", vpat, 6'b011100);
    drain();

    // Stall: hold output 4 cycles, block input, then resume with no loss or duplicate
    operand_A_i = 8'd12; operand_B_i = 8'd13; signed_i = 1'b0; valid_i = 1'b1;
    exp_q.push_back(16'h009C);
    tick();
    operand_A_i = 8'hF6; operand_B_i = 8'h0A; signed_i = 1'b1;
    exp_q.push_back(16'hFF9C);
    tick();
    operand_A_i = 8'h7F; operand_B_i = 8'h81; signed_i = 1'b1;
    ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check("stall_ready_o", ready_o, 0);
      check("stall_product", product_o, 16'h009C);
      tick();
    end
    ready_i = 1'b1;
    send(8'h7F, 8'h81, 1'b1, 16'hC0FF);
    drain();

    // Reset with two operations in flight
    send(8'd9, 8'd9, 1'b0, 16'h0051);
    send(8'd5, 8'd6, 1'b0, 16'h001E);
    rst_i = 1'b1;
    #1;
    check("midreset_valid_o", valid_o, 0);
    check("midreset_product_o", product_o, 0);
    exp_q.delete();
    repeat (2) tick();
    rst_i = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (valid_o) quiet = 1'b0;
    end
    check("post_reset_quiet", quiet, 1);
    tick();
    send(8'd17, 8'd3, 1'b0, 16'h0033);
    drain();

`ifdef LONG_MULT_FLUSH_EN
    // Flush with two in flight and the output stalled; input presented with flush is dropped
    send(8'd20, 8'd20, 1'b0, 16'h0190);
    send(8'd21, 8'd2, 1'b0, 16'h002A);
    ready_i = 1'b0;
    tick();
    flush_i = 1'b1;
    operand_A_i = 8'd50; operand_B_i = 8'd50; signed_i = 1'b0; valid_i = 1'b1;
    @(negedge clk_i);
    check("flush_ready_o", ready_o, 1);
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    check("flush_valid_o", valid_o, 0);
    ready_i = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (valid_o) quiet = 1'b0;
    end
    check("post_flush_quiet", quiet, 1);
    tick();
    send(8'hF0, 8'h10, 1'b1, 16'hFF00);
    drain();
`endif

    // Random mix with random backpressure
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          a = pick_operand();
          b = pick_operand();
          s = 1'($urandom_range(0, 1));
          send(a, b, s, ref_mul(a, b, s));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk_i);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
